mesh_terminal_injector: RTL and testbench

Per-terminal packet source that sits directly upstream of one terminal port of the `mesh_gnrtr` router mesh. It accepts destination/payload requests over a valid/ready handshake and formats them into mesh packets. Packets are buffered in a show-ahead FIFO and presented on the router's terminal-input handshake (`pndng_i_in` / `data_out_i_in` / `popin`). It also keeps injection and drop statistics for the checker and scoreboard.

---
 rtl/mesh_terminal_injector.sv | 177 +++++++++++++++++
 tb/tb_mesh_terminal_injector.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mesh_terminal_injector.sv
// mesh_terminal_injector
//
// Packet source for one terminal port of the mesh_gnrtr router mesh.
// Requests (destination row/col, routing mode, payload) arrive on a
// valid/ready handshake. They are formatted into mesh packets and buffered in
// a show-ahead FIFO. The FIFO head is presented to the router as
// pndng / data_out, and the router takes it with popin.
//
// Optional feature macro: INJ_DEST_CHECK_EN
//   defined   - accepted requests with an illegal destination are consumed,
//               not stored, and counted in drop_count (saturating).
//   undefined - every accepted request is stored; drop_count is tied to 0.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   req_valid/ready request handshake (ready = not full, registered state only)
//   req_row/col     destination coordinates
//   req_mode        1 = row-first, 0 = column-first
//   req_payload     PAKG_SIZE-17 bit payload
//   pndng, data_out FIFO head towards the router
//   popin           router consumes the head this cycle
//   occupancy       packets currently stored
//   inj_count       packets popped by the router (wrapping)
//   drop_count      requests rejected by the destination check (saturating)
//   pop_err         sticky: popin seen while nothing was pending
module mesh_terminal_injector #(
   parameter int         ROWS       = 4,
   parameter int         COLUMNS    = 4,
   parameter int         PAKG_SIZE  = 32,
   parameter int         FIFO_DEPTH = 16,
   parameter logic [7:0] BDCST      = 8'hFF
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [3:0]                     req_row,
   input  logic [3:0]                     req_col,
   input  logic                           req_mode,
   input  logic [PAKG_SIZE-18:0]          req_payload,
   output logic                           pndng,
   output logic [PAKG_SIZE-1:0]           data_out,
   input  logic                           popin,
   output logic [$clog2(FIFO_DEPTH):0]    occupancy,
   output logic [15:0]                    inj_count,
   output logic [15:0]                    drop_count,
   output logic                           pop_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(FIFO_DEPTH);

   // Storage has no reset so it can map onto block RAM.
   logic [PAKG_SIZE-1:0] mem [FIFO_DEPTH];

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   logic [AW:0]          wr_ptr_reg;
   logic [AW:0]          rd_ptr_reg;
   logic [PAKG_SIZE-1:0] data_out_reg;
   logic [15:0]          inj_count_reg;
   logic                 pop_err_reg;

   logic [AW:0]          occ;
   logic                 full;
   logic                 empty;
   logic                 accept;
   logic                 legal;
   logic                 push;
   logic                 pop;
   logic [AW-1:0]        rd_next_idx;
   logic [PAKG_SIZE-1:0] packet;

   assign occ         = wr_ptr_reg - rd_ptr_reg;
   assign full        = (occ == DEPTH_W);
   assign empty       = (occ == '0);
   assign accept      = req_valid && !full;
   assign push        = accept && legal;
   assign pop         = popin && !empty;
   assign rd_next_idx = rd_ptr_reg[AW-1:0] + 1'b1;
   assign packet      = {8'h00, req_row, req_col, req_mode, req_payload};

`ifdef INJ_DEST_CHECK_EN
   localparam logic [4:0] ROW_EDGE = 5'(ROWS + 1);
   localparam logic [4:0] COL_EDGE = 5'(COLUMNS + 1);
   localparam logic [4:0] ROW_MAX  = 5'(ROWS);
   localparam logic [4:0] COL_MAX  = 5'(COLUMNS);

   logic [4:0]  row_x;
   logic [4:0]  col_x;
   logic        drop;
   logic [15:0] drop_count_reg;

   assign row_x = {1'b0, req_row};
   assign col_x = {1'b0, req_col};

   // Terminals sit on the mesh border: the north/south ring (row 0 or
   // ROWS+1) and the west/east ring (col 0 or COLUMNS+1). Corners are not
   // terminals. The broadcast code is always allowed.
   always_comb begin
      legal = 1'b0;
      if ({req_row, req_col} == BDCST)
         legal = 1'b1;
      else if (((row_x == 5'd0) || (row_x == ROW_EDGE)) &&
               (col_x >= 5'd1) && (col_x <= COL_MAX))
         legal = 1'b1;
      else if (((col_x == 5'd0) || (col_x == COL_EDGE)) &&
               (row_x >= 5'd1) && (row_x <= ROW_MAX))
         legal = 1'b1;
   end

   assign drop = accept && !legal;

   always_ff @(posedge clk) begin
      if (reset)
         drop_count_reg <= 16'd0;
      else if (drop && (drop_count_reg != 16'hFFFF))
         drop_count_reg <= drop_count_reg + 16'd1;
   end

   assign drop_count = drop_count_reg;
`else
   assign legal      = 1'b1;
   assign drop_count = 16'd0;
`endif

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg[AW-1:0]] <= packet;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   // The head is kept in a register loaded one cycle ahead. With two or more
   // entries the next head is already in memory. When the incoming packet
   // becomes the head, it is loaded straight from the request instead. That
   // happens when pushing into an empty FIFO, or when pushing and popping
   // the last entry together. When a pop empties the FIFO the register
   // keeps its old value.
   always_ff @(posedge clk) begin
      if (reset)
         data_out_reg <= '0;
      else if (pop && (occ > (AW+1)'(1)))
         data_out_reg <= mem[rd_next_idx];
      else if (push && (empty || pop))
         data_out_reg <= packet;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         inj_count_reg <= 16'd0;
         pop_err_reg   <= 1'b0;
      end else begin
         if (pop)
            inj_count_reg <= inj_count_reg + 16'd1;
         if (popin && empty)
            pop_err_reg <= 1'b1;
      end
   end

   assign req_ready = !full;
   assign pndng     = !empty;
   assign data_out  = data_out_reg;
   assign occupancy = occ;
   assign inj_count = inj_count_reg;
   assign pop_err   = pop_err_reg;

endmodule

// File: tb/tb_mesh_terminal_injector.sv
// Testbench for mesh_terminal_injector (default parameters).
// The reference model is a packet queue plus counters. It is updated once
// per clock edge, and one compare process checks every DUT output against
// it on each falling edge. Literal checks pin the model at key points.
module tb_mesh_terminal_injector;

   localparam int PS    = 32;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [3:0]    req_row = '0;
   logic [3:0]    req_col = '0;
   logic          req_mode = 1'b0;
   logic [PS-18:0] req_payload = '0;
   logic          pndng;
   logic [PS-1:0] data_out;
   logic          popin = 1'b0;
   logic [4:0]    occupancy;
   logic [15:0]   inj_count;
   logic [15:0]   drop_count;
   logic          pop_err;

   mesh_terminal_injector dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_row(req_row), .req_col(req_col), .req_mode(req_mode),
      .req_payload(req_payload),
      .pndng(pndng), .data_out(data_out), .popin(popin),
      .occupancy(occupancy), .inj_count(inj_count),
      .drop_count(drop_count), .pop_err(pop_err)
   );

   always #5 clk = ~clk;

   // Reference model state.
   logic [PS-1:0] mq[$];
   logic [PS-1:0] m_last = '0;
   int            m_inj = 0;
   int            m_drop = 0;
   bit            m_perr = 1'b0;

   int  n_checks = 0;
   int  n_pass   = 0;
   bit  check_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic bit legal(input logic [3:0] r, input logic [3:0] c);
`ifdef INJ_DEST_CHECK_EN
      int ri = int'(r);
      int ci = int'(c);
      if (r == 4'hF && c == 4'hF) return 1'b1;
      if ((ri == 0 || ri == 5) && ci >= 1 && ci <= 4) return 1'b1;
      if ((ci == 0 || ci == 5) && ri >= 1 && ri <= 4) return 1'b1;
      return 1'b0;
`else
      return 1'b1;
`endif
   endfunction

   // One compare process, every cycle, against the model.
   always @(negedge clk) begin
      if (check_en) begin
         chk("req_ready", 64'(req_ready), 64'(mq.size() < DEPTH));
         chk("pndng",     64'(pndng),     64'(mq.size() != 0));
         chk("occupancy", 64'(occupancy), 64'(mq.size()));
         chk("data_out",  64'(data_out),  64'(m_last));
         chk("inj_count", 64'(inj_count), 64'(m_inj));
         chk("drop_count",64'(drop_count),64'(m_drop));
         chk("pop_err",   64'(pop_err),   64'(m_perr));
      end
   end

   // Drive one cycle of inputs, let the edge happen, update the model.
   task automatic step(input bit v, input logic [3:0] r, input logic [3:0] c,
                       input bit m, input logic [PS-18:0] p, input bit pp, input bit rst);
      bit acc;
      bit do_pop;
      bit bad_pop;
      logic [PS-1:0] pkt;
      req_valid = v; req_row = r; req_col = c; req_mode = m; req_payload = p;
      popin = pp; reset = rst;
      acc     = v && (mq.size() < DEPTH);
      do_pop  = pp && (mq.size() != 0);
      bad_pop = pp && (mq.size() == 0);
      pkt     = {8'h00, r, c, m, p};
      @(posedge clk);
      if (rst) begin
         mq.delete(); m_last = '0; m_inj = 0; m_drop = 0; m_perr = 1'b0;
      end else begin
         if (bad_pop) m_perr = 1'b1;
         if (do_pop) begin
            void'(mq.pop_front());
            m_inj = (m_inj + 1) % 65536;
         end
         if (acc) begin
            if (legal(r, c)) mq.push_back(pkt);
            else if (m_drop < 65535) m_drop++;
         end
         if (mq.size() != 0) m_last = mq[0];
      end
      @(negedge clk);
      $display("cyc v=%0b acc=%0b dst=%0h,%0h pop=%0b rst=%0b occ=%0d data=%0h",
               v, acc, r, c, pp, rst, occupancy, data_out);
   endtask

   task automatic idle(input bit pp);
      step(1'b0, 4'h0, 4'h0, 1'b0, '0, pp, 1'b0);
   endtask

   task automatic push_legal(input bit pp);
      step(1'b1, 4'h0, 4'($urandom_range(1, 4)), 1'($urandom),
           15'($urandom), pp, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, 4'h0, 4'h0, 1'b0, '0, 1'b0, 1'b1);
   endtask

   initial begin
      @(negedge clk);
      do_reset();
      check_en = 1'b1;
      do_reset();
      chk("rst_data_out", 64'(data_out), 64'h0);
      chk("rst_ready",    64'(req_ready), 64'h1);

      // Single packet, literal expectation.
      step(1'b1, 4'h0, 4'h2, 1'b1, 15'h1234, 1'b0, 1'b0);
      chk("lit_pndng", 64'(pndng), 64'h1);
      chk("lit_packet", 64'(data_out), 64'h0002_9234);
      idle(1'b1);
      chk("lit_pndng_after_pop", 64'(pndng), 64'h0);
      chk("lit_inj1", 64'(inj_count), 64'h1);

      // Fill to full; held 17th request waits for a pop.
      do_reset();
      for (int i = 0; i < DEPTH; i++) push_legal(1'b0);
      chk("lit_full_occ", 64'(occupancy), 64'd16);
      chk("lit_full_ready", 64'(req_ready), 64'h0);
      step(1'b1, 4'h5, 4'h3, 1'b0, 15'h7777, 1'b0, 1'b0);
      step(1'b1, 4'h5, 4'h3, 1'b0, 15'h7777, 1'b1, 1'b0);
      chk("lit_after_pop_occ", 64'(occupancy), 64'd15);
      step(1'b1, 4'h5, 4'h3, 1'b0, 15'h7777, 1'b0, 1'b0);
      chk("lit_17th_in", 64'(occupancy), 64'd16);
      for (int i = 0; i < DEPTH; i++) idle(1'b1);
      chk("lit_drained", 64'(pndng), 64'h0);

      // Steady push+pop at occupancy 5 across pointer wrap.
      do_reset();
      for (int i = 0; i < 5; i++) push_legal(1'b0);
      for (int i = 0; i < 20; i++) push_legal(1'b1);
      chk("lit_steady_occ", 64'(occupancy), 64'd5);
      chk("lit_steady_inj", 64'(inj_count), 64'd20);

      // Pop while empty.
      do_reset();
      idle(1'b1);
      chk("lit_pop_err", 64'(pop_err), 64'h1);
      idle(1'b0);
      chk("lit_pop_err_sticky", 64'(pop_err), 64'h1);
      chk("lit_pop_err_occ", 64'(occupancy), 64'h0);
      chk("lit_pop_err_inj", 64'(inj_count), 64'h0);

      // Destination check.
      do_reset();
      step(1'b1, 4'h2, 4'h2, 1'b0, 15'h0042, 1'b0, 1'b0);
`ifdef INJ_DEST_CHECK_EN
      chk("lit_drop_cnt", 64'(drop_count), 64'h1);
      chk("lit_drop_pndng", 64'(pndng), 64'h0);
`else
      chk("lit_nodrop_pndng", 64'(pndng), 64'h1);
      chk("lit_nodrop_cnt", 64'(drop_count), 64'h0);
`endif
      step(1'b1, 4'hF, 4'hF, 1'b1, 15'h0043, 1'b0, 1'b0);
      chk("lit_bdcst_pndng", 64'(pndng), 64'h1);

      // Reset mid-operation.
      do_reset();
      for (int i = 0; i < 7; i++) push_legal(1'b0);
      idle(1'b1);
      do_reset();
      chk("lit_rst_occ", 64'(occupancy), 64'h0);
      chk("lit_rst_pndng", 64'(pndng), 64'h0);
      chk("lit_rst_inj", 64'(inj_count), 64'h0);
      chk("lit_rst_ready", 64'(req_ready), 64'h1);

      // Randomized traffic, including illegal destinations and empty pops.
      for (int i = 0; i < 3000; i++) begin
         logic [3:0] r;
         logic [3:0] c;
         int sel;
         sel = $urandom_range(0, 9);
         if (sel == 0) begin r = 4'hF; c = 4'hF; end
         else if (sel < 4) begin r = 4'h0; c = 4'($urandom_range(1, 4)); end
         else if (sel < 6) begin c = 4'h5; r = 4'($urandom_range(1, 4)); end
         else begin r = 4'($urandom_range(0, 15)); c = 4'($urandom_range(0, 15)); end
         step(($urandom_range(0, 99) < 55), r, c, 1'($urandom), 15'($urandom),
              ($urandom_range(0, 99) < (i < 1500 ? 35 : 65)),
              ($urandom_range(0, 999) == 0));
      end

      check_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
